// File: rtl/axis_pkt_rx.sv
// Store-and-forward AXI-Stream receiver: beats are buffered in a circular memory and
// a packet is released to the read port only once its tlast beat arrives error-free.
//
// state   | meaning
// RECV    | writing beats of the current packet into the buffer
// DISCARD | swallowing the remainder of a packet too large to ever fit
module axis_pkt_rx #(
  parameter int N     = 4,
  parameter int U     = 1,
  parameter int DEPTH = 16
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [8*N-1:0] s_tdata,
  input  logic [N-1:0]   s_tkeep,
  input  logic           s_tlast,
  input  logic [U-1:0]   s_tuser,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [8*N-1:0] rd_data,
  output logic [N-1:0]   rd_keep,
  output logic           rd_last,
  output logic           pkt_avail,
  output logic [15:0]    rx_pkt_cnt,
  output logic [15:0]    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 8*N + N + 1;

  typedef enum logic [0:0] {RECV, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [PW-1:0] commit_ptr, commit_ptr_d;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] used, partial;
  logic          full, load;
  logic          mem_we, rx_inc, drop_inc;
  logic [EW-1:0] mem [DEPTH];

  assign used      = wr_ptr - rd_ptr;
  assign partial   = wr_ptr - commit_ptr;
  assign full      = (used == PW'(DEPTH));
  assign load      = (rd_ptr != commit_ptr) && (!rd_valid || rd_ready);
  assign pkt_avail = rd_valid || (rd_ptr != commit_ptr);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr;
    commit_ptr_d = commit_ptr;
    mem_we       = 1'b0;
    rx_inc       = 1'b0;
    drop_inc     = 1'b0;
    s_tready     = 1'b0;
    case (state_q)
      RECV: begin
        s_tready = aresetn && !full;
        // A packet that has filled the whole buffer by itself can never commit.
        if (full && partial == PW'(DEPTH)) begin
          wr_ptr_d = commit_ptr;
          drop_inc = 1'b1;
          state_d  = DISCARD;
        end else if (s_tvalid && s_tready) begin
          if (s_tlast && s_tuser[0]) begin
            wr_ptr_d = commit_ptr;
            drop_inc = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr + 1'b1;
            if (s_tlast) begin
              commit_ptr_d = wr_ptr + 1'b1;
              rx_inc       = 1'b1;
            end
          end
        end
      end
      DISCARD: begin
        s_tready = aresetn;
        if (s_tvalid && s_tready && s_tlast) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= RECV;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_keep    <= '0;
      rd_last    <= 1'b0;
      rx_pkt_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr     <= wr_ptr_d;
      commit_ptr <= commit_ptr_d;
      if (rx_inc) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (load) begin
        rd_ptr                      <= rd_ptr + 1'b1;
        {rd_last, rd_keep, rd_data} <= mem[rd_ptr[AW-1:0]];
        rd_valid                    <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Bench for axis_pkt_rx: committed beats are queued as they are driven and
// compared in order as the read port pops them.
module tb_axis_pkt_rx;
  localparam int N     = 4;
  localparam int U     = 1;
  localparam int DEPTH = 16;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           s_tvalid, s_tready, s_tlast;
  logic [8*N-1:0] s_tdata;
  logic [N-1:0]   s_tkeep;
  logic [U-1:0]   s_tuser;
  logic           rd_valid, rd_ready, rd_last, pkt_avail;
  logic [8*N-1:0] rd_data;
  logic [N-1:0]   rd_keep;
  logic [15:0]    rx_pkt_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_rx = 0;
  int exp_drop = 0;
  logic [8*N+N:0] sb [$];

  axis_pkt_rx #(.N(N), .U(U), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_keep(rd_keep), .rd_last(rd_last), .pkt_avail(pkt_avail),
    .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  // Read-side scoreboard
  always @(negedge aclk) begin
    logic [8*N+N:0] exp_b;
    if (aresetn && rd_valid && rd_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h expected no beat", {rd_last, rd_keep, rd_data});
      end else begin
        exp_b = sb.pop_front();
        if ({rd_last, rd_keep, rd_data} !== exp_b) begin
          errors++;
          $display("FAIL sb_beat got %h expected %h", {rd_last, rd_keep, rd_data}, exp_b);
        end
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic send_beat(input logic [8*N-1:0] d, input logic [N-1:0] k,
                           input logic l, input logic u, output int stalls);
    logic hs;
    stalls   = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    while (1) begin
      @(negedge aclk);
      hs = s_tready;
      @(posedge aclk);
      #1;
      if (hs) break;
      stalls++;
      if (stalls > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got s_tready=0 expected handshake");
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
  endtask

  task automatic send_pkt(input int len, input bit err, input bit push, output int stalls);
    logic [8*N-1:0] d;
    logic [N-1:0]   k;
    logic           l;
    int             st;
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      d = $urandom();
      k = N'($urandom_range(1, (1 << N) - 1));
      l = (i == len - 1);
      if (push) sb.push_back({l, k, d});
      send_beat(d, k, l, err && l, st);
      stalls += st;
    end
  endtask

  task automatic drain();
    int n = 0;
    rd_ready = 1'b1;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (3) begin @(posedge aclk); #1; end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL drain got %0d beats left expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
    rd_ready = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
    @(negedge aclk);
    checks++;
    if ({s_tready, rd_valid, rd_last, pkt_avail} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 0000", {s_tready, rd_valid, rd_last, pkt_avail});
    end
    checks++;
    if ({rd_data, rd_keep} !== '0) begin
      errors++;
      $display("FAIL reset_rd got %h expected 0", {rd_data, rd_keep});
    end
    checks++;
    if (rx_pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got rx=%0d drop=%0d expected 0 0", rx_pkt_cnt, drop_cnt);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b expected 1", s_tready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_single();
    int st;
    rd_ready = 1'b1;
    send_pkt(3, 1'b0, 1'b1, st);
    exp_rx++;
    @(negedge aclk);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL commit_latency_k1 got %b expected 0", rd_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_pop%0d got rd_valid=%b expected 1", i, rd_valid);
      end
    end
    @(negedge aclk);
    checks++;
    if (rd_valid !== 1'b0 || pkt_avail !== 1'b0) begin
      errors++;
      $display("FAIL single_empty got valid=%b avail=%b expected 0 0", rd_valid, pkt_avail);
    end
    @(posedge aclk); #1;
    drain();
    checks++;
    if (rx_pkt_cnt !== 16'(exp_rx)) begin
      errors++;
      $display("FAIL single_rx_cnt got %0d expected %0d", rx_pkt_cnt, exp_rx);
    end
  endtask

  task automatic test_error();
    int st;
    rd_ready = 1'b1;
    send_pkt(5, 1'b1, 1'b0, st);
    exp_drop++;
    repeat (4) begin @(posedge aclk); #1; end
    @(negedge aclk);
    checks++;
    if (rd_valid !== 1'b0 || pkt_avail !== 1'b0) begin
      errors++;
      $display("FAIL err_no_output got valid=%b avail=%b expected 0 0", rd_valid, pkt_avail);
    end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL err_drop_cnt got %0d expected %0d", drop_cnt, exp_drop);
    end
    @(posedge aclk); #1;
    // Without the rewind the stale beats would precede this packet.
    send_pkt(2, 1'b0, 1'b1, st);
    exp_rx++;
    drain();
    checks++;
    if (rx_pkt_cnt !== 16'(exp_rx)) begin
      errors++;
      $display("FAIL err_rx_cnt got %0d expected %0d", rx_pkt_cnt, exp_rx);
    end
  endtask

  task automatic test_oversize();
    int st, total, stall_beat;
    rd_ready   = 1'b0;
    total      = 0;
    stall_beat = 0;
    for (int i = 1; i <= 20; i++) begin
      send_beat($urandom(), '1, i == 20, 1'b0, st);
      if (st != 0 && stall_beat == 0) stall_beat = i;
      total += st;
    end
    exp_drop++;
    checks++;
    if (total !== 1 || stall_beat !== 17) begin
      errors++;
      $display("FAIL oversize_stall got %0d stalls at beat %0d expected 1 at beat 17", total, stall_beat);
    end
    repeat (2) begin @(posedge aclk); #1; end
    @(negedge aclk);
    checks++;
    if (drop_cnt !== 16'(exp_drop) || pkt_avail !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL oversize_drop got drop=%0d avail=%b valid=%b expected %0d 0 0",
               drop_cnt, pkt_avail, rd_valid, exp_drop);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL oversize_recover got s_tready=%b expected 1", s_tready);
    end
    @(posedge aclk); #1;
  endtask

  // The output register pulls the first committed beat out of the memory, so the
  // buffer plus register hold 17 beats and the 18th is the first to stall.
  task automatic test_backpressure();
    int st, total;
    logic [8*N-1:0] d5 [4];
    logic [N-1:0]   k5 [4];
    rd_ready = 1'b0;
    total    = 0;
    for (int p = 0; p < 4; p++) begin
      send_pkt(4, 1'b0, 1'b1, st);
      total += st;
      exp_rx++;
    end
    for (int i = 0; i < 4; i++) begin
      d5[i] = $urandom();
      k5[i] = N'($urandom_range(1, (1 << N) - 1));
      sb.push_back({i == 3, k5[i], d5[i]});
    end
    send_beat(d5[0], k5[0], 1'b0, 1'b0, st);
    total += st;
    checks++;
    if (total !== 0) begin
      errors++;
      $display("FAIL bp_fill_stalls got %0d expected 0", total);
    end
    s_tvalid = 1'b1; s_tdata = d5[1]; s_tkeep = k5[1]; s_tlast = 1'b0; s_tuser = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if (s_tready !== 1'b0) begin
        errors++;
        $display("FAIL bp_full_c%0d got s_tready=%b expected 0", c, s_tready);
      end
      @(posedge aclk); #1;
    end
    rd_ready = 1'b1;
    @(posedge aclk); #1;
    rd_ready = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL bp_freed got s_tready=%b expected 1", s_tready);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL bp_refull got s_tready=%b expected 0", s_tready);
    end
    @(posedge aclk); #1;
    rd_ready = 1'b1;
    send_beat(d5[2], k5[2], 1'b0, 1'b0, st);
    send_beat(d5[3], k5[3], 1'b1, 1'b0, st);
    exp_rx++;
    drain();
    checks++;
    if (drop_cnt !== 16'(exp_drop) || rx_pkt_cnt !== 16'(exp_rx)) begin
      errors++;
      $display("FAIL bp_counts got rx=%0d drop=%0d expected %0d %0d", rx_pkt_cnt, drop_cnt, exp_rx, exp_drop);
    end
  endtask

  task automatic test_throughput();
    bit done = 0;
    int st;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          send_pkt($urandom_range(1, 16), 1'b0, 1'b1, st);
          exp_rx++;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #1;
          rd_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    checks++;
    if (rx_pkt_cnt !== 16'(exp_rx) || drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL tput_counts got rx=%0d drop=%0d expected %0d %0d", rx_pkt_cnt, drop_cnt, exp_rx, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    int st;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat($urandom(), '1, 1'b0, 1'b0, st);
    aresetn = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready got %b expected 0", s_tready);
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (rd_valid !== 1'b0 || pkt_avail !== 1'b0 || rx_pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_state got valid=%b avail=%b rx=%0d drop=%0d expected 0 0 0 0",
               rd_valid, pkt_avail, rx_pkt_cnt, drop_cnt);
    end
    @(posedge aclk); #1;
    aresetn  = 1'b1;
    exp_rx   = 0;
    exp_drop = 0;
    sb.delete();
    send_pkt(2, 1'b0, 1'b1, st);
    exp_rx++;
    drain();
    checks++;
    if (rx_pkt_cnt !== 16'(exp_rx) || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_after got rx=%0d drop=%0d expected %0d 0", rx_pkt_cnt, drop_cnt, exp_rx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_error();
    test_oversize();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
